// File: rtl/seq_pkg.sv
// Shared definitions for the seq calculator serial path: UART receiver states,
// instruction opcodes and default line timing.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_MULT = 2'b10;
    localparam logic [1:0] OP_SEND = 2'b11;

    localparam int DEF_CLK_HZ = 100_000_000;
    localparam int DEF_BAUD   = 1_000_000;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter with synchronous clear; flags the half-bit and
// last-cycle-of-bit points so both the receive and transmit sides can share it.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_half,
    output logic o_full
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_count;

    // Wraps to zero after the last cycle so consecutive data bits stay one period apart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear || (r_count == LAST_CNT)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_half = (r_count == HALF_CNT);
    assign o_full = (r_count == LAST_CNT);

endmodule

// File: rtl/uart_inst_rx.sv
// 8N1 UART receiver that turns serial bytes into instruction words on the same
// inst_wd/inst_vld strobe interface the button/switch path uses.
module uart_inst_rx
    import seq_pkg::*;
#(
    parameter int CLK_HZ = DEF_CLK_HZ,
    parameter int BAUD   = DEF_BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RsRx,
    output logic [7:0] inst_wd,
    output logic       inst_vld,
    output logic       frm_err,
    output logic       rx_busy
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    logic [1:0]  r_sync;
    uart_state_t r_state;
    uart_state_t w_stateNext;
    logic [7:0]  r_shreg;
    logic [2:0]  r_bitIdx;
    logic [7:0]  r_instWd;
    logic        r_instVld;
    logic        r_frmErr;
    logic        w_rxS;
    logic        w_clear;
    logic        w_half;
    logic        w_full;

    // Idle-high reset value keeps a released line from looking like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], RsRx};
        end
    end

    assign w_rxS = r_sync[1];

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_clear),
        .o_half  (w_half),
        .o_full  (w_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (!w_rxS) w_stateNext = START;
            START:   if (w_half) w_stateNext = w_rxS ? IDLE : DATA;
            DATA:    if (w_full && (r_bitIdx == 3'd7)) w_stateNext = STOP;
            STOP:    if (w_full) w_stateNext = w_rxS ? IDLE : BREAK;
            BREAK:   if (w_rxS) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
        w_clear = (w_stateNext != r_state);
    end

    // A low stop bit leaves inst_wd untouched so the consumer never sees a torn byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg   <= '0;
            r_bitIdx  <= '0;
            r_instWd  <= '0;
            r_instVld <= 1'b0;
            r_frmErr  <= 1'b0;
        end else begin
            r_instVld <= 1'b0;
            r_frmErr  <= 1'b0;
            if (r_state == START) begin
                r_bitIdx <= '0;
            end
            if ((r_state == DATA) && w_full) begin
                r_shreg[r_bitIdx] <= w_rxS;
                r_bitIdx          <= r_bitIdx + 3'd1;
            end
            if ((r_state == STOP) && w_full) begin
                if (w_rxS) begin
                    r_instWd  <= r_shreg;
                    r_instVld <= 1'b1;
                end else begin
                    r_frmErr <= 1'b1;
                end
            end
        end
    end

    assign inst_wd  = r_instWd;
    assign inst_vld = r_instVld;
    assign frm_err  = r_frmErr;
    assign rx_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_uart_inst_rx.sv
// Directed bench for uart_inst_rx: a UART line model drives RsRx and a scoreboard
// queue matches each received instruction byte against what was sent.
module tb_uart_inst_rx;

    localparam int  BIT_NS = 1000;

    logic       clk;
    logic       rst_n;
    logic       RsRx;
    logic [7:0] inst_wd;
    logic       inst_vld;
    logic       frm_err;
    logic       rx_busy;

    int         nCompared   = 0;
    int         nMismatched = 0;
    int         cycle       = 0;
    int         vldCount    = 0;
    int         frmErrCount = 0;
    int         lastVldCycle = 0;
    int         expVldTotal = 0;
    int         edgeCycle;
    int         latency;
    logic       prevVld = 1'b0;
    logic [7:0] expQ[$];

    uart_inst_rx #(
        .CLK_HZ(100_000_000),
        .BAUD  (1_000_000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RsRx     (RsRx),
        .inst_wd  (inst_wd),
        .inst_vld (inst_vld),
        .frm_err  (frm_err),
        .rx_busy  (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Line model: start bit, eight data bits LSB first, then the chosen stop level.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic doPush);
        if (doPush) begin
            expQ.push_back(data);
            expVldTotal++;
        end
        RsRx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            RsRx = data[i];
            #(BIT_NS);
        end
        RsRx = stopBit;
        #(BIT_NS);
    endtask

    task automatic drainQueue(input string tag);
        for (int i = 0; i < 3000 && expQ.size() != 0; i++) @(negedge clk);
        checkOutput(tag, expQ.size(), 0);
    endtask

    // Scoreboard side: every strobe pops one expected byte and must be a single cycle.
    always @(negedge clk) begin
        if (inst_vld) begin
            vldCount++;
            lastVldCycle = cycle;
            checkOutput("vld_one_cycle", prevVld, 1'b0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_vld", 1, 0);
            end else begin
                checkOutput("inst_wd", inst_wd, expQ.pop_front());
            end
        end
        if (frm_err) begin
            frmErrCount++;
            checkOutput("vld_frm_exclusive", inst_vld, 1'b0);
        end
        prevVld = inst_vld;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        RsRx  = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("rst_inst_wd", inst_wd, 8'h00);
        checkOutput("rst_inst_vld", inst_vld, 1'b0);
        checkOutput("rst_frm_err", frm_err, 1'b0);
        checkOutput("rst_rx_busy", rx_busy, 1'b0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("[TB] single frame 0x13");
        edgeCycle = cycle;
        applyStimulus(8'h13, 1'b1, 1'b1);
        drainQueue("drain_single");
        latency = lastVldCycle - edgeCycle;
        checkOutput("latency_window", (latency >= 950 && latency <= 955), 1'b1);
        checkOutput("vld_count_single", vldCount, 1);

        $display("[TB] back-to-back frames");
        applyStimulus(8'h04, 1'b1, 1'b1);
        applyStimulus(8'hC0, 1'b1, 1'b1);
        applyStimulus(8'h9E, 1'b1, 1'b1);
        drainQueue("drain_b2b");
        checkOutput("vld_count_b2b", vldCount, 4);

        $display("[TB] glitch rejection");
        repeat (20) @(negedge clk);
        RsRx = 1'b0;
        #300;
        RsRx = 1'b1;
        checkOutput("glitch_busy_high", rx_busy, 1'b1);
        repeat (40) @(negedge clk);
        checkOutput("glitch_busy_low", rx_busy, 1'b0);
        checkOutput("glitch_no_vld", vldCount, 4);
        checkOutput("glitch_no_frm_err", frmErrCount, 0);

        $display("[TB] framing error and break");
        repeat (20) @(negedge clk);
        applyStimulus(8'h55, 1'b0, 1'b0);
        RsRx = 1'b0;
        #10000;
        checkOutput("break_busy", rx_busy, 1'b1);
        checkOutput("frm_err_once", frmErrCount, 1);
        checkOutput("wd_held", inst_wd, 8'h9E);
        #10000;
        RsRx = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("break_exit", rx_busy, 1'b0);
        #1000;
        applyStimulus(8'h66, 1'b1, 1'b1);
        drainQueue("drain_after_break");

        $display("[TB] reset mid-frame");
        repeat (20) @(negedge clk);
        fork
            applyStimulus(8'hA5, 1'b1, 1'b0);
            begin
                #4503;
                checkOutput("busy_before_reset", rx_busy, 1'b1);
                rst_n = 1'b0;
                #1;
                checkOutput("async_rst_wd", inst_wd, 8'h00);
                checkOutput("async_rst_busy", rx_busy, 1'b0);
                checkOutput("async_rst_vld", inst_vld, 1'b0);
            end
        join
        #200;
        rst_n = 1'b1;
        #1000;
        applyStimulus(8'h3C, 1'b1, 1'b1);
        drainQueue("drain_after_reset");

        $display("[TB] byte sweep");
        for (int v = 0; v < 256; v += 17) begin
            applyStimulus(v[7:0], 1'b1, 1'b1);
        end
        for (int b = 0; b < 8; b++) begin
            applyStimulus(8'(1 << b), 1'b1, 1'b1);
        end
        drainQueue("drain_sweep");

        checkOutput("vld_total", vldCount, expVldTotal);
        checkOutput("frm_err_total", frmErrCount, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
